// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC register and IF/ID pipeline register.
// Holds a redirect that arrives during a stall until the stall is released.
//
// state | meaning
// IDLE  | no redirect waiting; PC steps by 4 or takes a live redirect
// HELD  | a redirect arrived while stalled; pend_tgt applies when the stall drops
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int          IM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] npc_target,
    input  logic        flush_d,
    input  logic [31:0] im_rdata,
    output logic [31:0] im_addr,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc8_d,
    output logic        valid_d,
    output logic        adel_d
);

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } pend_state_t;

    // Upper bound in 33 bits so a window ending at 2^32 cannot wrap.
    localparam logic [32:0] IM_LO = {1'b0, IM_BASE};
    localparam logic [32:0] IM_HI = {1'b0, IM_BASE} + (33'(IM_WORDS) * 33'd4);

    pend_state_t state_q, state_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic [31:0] pc_q, pc_next;
    logic        fetch_err;

    logic [31:0] instr_q, instr_next;
    logic [31:0] pc_d_q, pc_d_next;
    logic        valid_q, valid_next;
    logic        adel_q, adel_next;

    always_comb begin
        state_d    = state_q;
        pend_tgt_d = pend_tgt_q;
        case (state_q)
            IDLE: begin
                if (stall && redirect) begin
                    state_d    = HELD;
                    pend_tgt_d = npc_target;
                end
            end
            HELD: begin
                if (stall && redirect) begin
                    pend_tgt_d = npc_target;
                end
                if (!stall) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        pc_next = pc_q;
        if (stall) begin
            pc_next = pc_q;
        end else if (redirect) begin
            pc_next = npc_target;
        end else if (state_q == HELD) begin
            pc_next = pend_tgt_q;
        end else begin
            pc_next = pc_q + 32'd4;
        end
    end

    always_comb begin
        fetch_err = (pc_q[1:0] != 2'b00)
                  || ({1'b0, pc_q} < IM_LO)
                  || ({1'b0, pc_q} >= IM_HI);
    end

    // The word fetched alongside a redirect is the delay slot and is kept.
    always_comb begin
        instr_next = instr_q;
        pc_d_next  = pc_d_q;
        valid_next = valid_q;
        adel_next  = adel_q;
        if (stall) begin
            instr_next = instr_q;
        end else if (flush_d) begin
            instr_next = 32'd0;
            pc_d_next  = pc_q;
            valid_next = 1'b0;
            adel_next  = 1'b0;
        end else if (fetch_err) begin
            instr_next = 32'd0;
            pc_d_next  = pc_q;
            valid_next = 1'b1;
            adel_next  = 1'b1;
        end else begin
            instr_next = im_rdata;
            pc_d_next  = pc_q;
            valid_next = 1'b1;
            adel_next  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pend_tgt_q <= 32'd0;
            pc_q       <= RESET_PC;
            instr_q    <= 32'd0;
            pc_d_q     <= 32'd0;
            valid_q    <= 1'b0;
            adel_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_tgt_q <= pend_tgt_d;
            pc_q       <= pc_next;
            instr_q    <= instr_next;
            pc_d_q     <= pc_d_next;
            valid_q    <= valid_next;
            adel_q     <= adel_next;
        end
    end

    assign pc_f    = pc_q;
    assign im_addr = pc_q;
    assign instr_d = instr_q;
    assign pc_d    = pc_d_q;
    assign pc8_d   = pc_d_q + 32'd8;
    assign valid_d = valid_q;
    assign adel_d  = adel_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed test-plan scenarios followed by random
// stimulus, all compared against a cycle-level behavioural model.
module tb_fetch_pc_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] IM_BASE  = 32'h0000_3000;
    localparam int          IM_WORDS = 4096;

    logic        clk = 1'b0;
    logic        reset, stall, redirect, flush_d;
    logic [31:0] npc_target;
    logic [31:0] im_rdata, im_addr, pc_f, instr_d, pc_d, pc8_d;
    logic        valid_d, adel_d;

    int errors = 0;
    int checks = 0;

    // model state
    logic [31:0] m_pc, m_tgt, m_instr, m_pc_d;
    logic        m_pend, m_valid, m_adel;

    always #5 clk = ~clk;

    function automatic logic [31:0] im_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign im_rdata = im_word(im_addr);

    fetch_pc_unit #(
        .RESET_PC(RESET_PC),
        .IM_BASE (IM_BASE),
        .IM_WORDS(IM_WORDS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .redirect  (redirect),
        .npc_target(npc_target),
        .flush_d   (flush_d),
        .im_rdata  (im_rdata),
        .im_addr   (im_addr),
        .pc_f      (pc_f),
        .instr_d   (instr_d),
        .pc_d      (pc_d),
        .pc8_d     (pc8_d),
        .valid_d   (valid_d),
        .adel_d    (adel_d)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit legal_fetch(input logic [31:0] a);
        longint unsigned lo, hi, x;
        lo = IM_BASE;
        hi = lo + 4 * IM_WORDS;
        x  = a;
        return (a % 4 == 0) && (x >= lo) && (x < hi);
    endfunction

    // One clock: apply inputs, advance the model, then compare all outputs.
    task automatic cycle(input bit rst, input bit stl, input bit rdr,
                         input logic [31:0] tgt, input bit fls);
        reset = rst; stall = stl; redirect = rdr; npc_target = tgt; flush_d = fls;
        @(posedge clk);
        if (rst) begin
            m_pc = RESET_PC; m_pend = 0; m_tgt = 0;
            m_instr = 0; m_pc_d = 0; m_valid = 0; m_adel = 0;
        end else if (stl) begin
            if (rdr) begin
                m_pend = 1;
                m_tgt  = tgt;
            end
        end else begin
            m_pc_d = m_pc;
            if (fls) begin
                m_instr = 0; m_valid = 0; m_adel = 0;
            end else if (!legal_fetch(m_pc)) begin
                m_instr = 0; m_valid = 1; m_adel = 1;
            end else begin
                m_instr = im_word(m_pc); m_valid = 1; m_adel = 0;
            end
            if (rdr)         m_pc = tgt;
            else if (m_pend) m_pc = m_tgt;
            else             m_pc = m_pc + 32'd4;
            m_pend = 0;
        end
        #1;
        check("pc_f",    pc_f,    m_pc);
        check("im_addr", im_addr, m_pc);
        check("instr_d", instr_d, m_instr);
        check("pc_d",    pc_d,    m_pc_d);
        check("pc8_d",   pc8_d,   m_pc_d + 32'd8);
        check("valid_d", {31'd0, valid_d}, {31'd0, m_valid});
        check("adel_d",  {31'd0, adel_d},  {31'd0, m_adel});
    endtask

    task automatic free_cycle();
        cycle(0, 0, 0, 32'd0, 0);
    endtask

    logic [31:0] frz_pc, frz_instr, frz_pc_d;
    logic [31:0] tgt;

    initial begin
        reset = 1; stall = 0; redirect = 0; npc_target = 0; flush_d = 0;
        m_pc = 0; m_tgt = 0; m_pend = 0; m_instr = 0; m_pc_d = 0; m_valid = 0; m_adel = 0;

        // reset and sequential stepping
        cycle(1, 0, 0, 32'd0, 0);
        check("rst_pc",    pc_f, 32'h0000_3000);
        check("rst_pc8",   pc8_d, 32'd8);
        check("rst_valid", {31'd0, valid_d}, 32'd0);
        free_cycle(); check("seq1", pc_f, 32'h3004);
        check("seq1_valid", {31'd0, valid_d}, 32'd1);
        free_cycle(); check("seq2", pc_f, 32'h3008);
        free_cycle(); check("seq3", pc_f, 32'h300C);
        free_cycle(); check("seq4", pc_f, 32'h3010);

        // redirect with delay slot
        cycle(0, 0, 1, 32'h3100, 0);
        check("rd_pc", pc_f, 32'h3100);
        check("rd_slot", pc_d, 32'h3010);
        free_cycle();
        check("rd_tgt_d", pc_d, 32'h3100);

        // stall with redirect on 2nd stalled cycle
        cycle(0, 0, 1, 32'h3020, 0);
        check("to3020", pc_f, 32'h3020);
        frz_pc = pc_f; frz_instr = instr_d; frz_pc_d = pc_d;
        cycle(0, 1, 0, 32'd0, 0);
        cycle(0, 1, 1, 32'h3200, 0);
        cycle(0, 1, 0, 32'd0, 0);
        check("stall_pc",    pc_f,    frz_pc);
        check("stall_instr", instr_d, frz_instr);
        check("stall_pc_d",  pc_d,    frz_pc_d);
        free_cycle();
        check("held_apply", pc_f, 32'h3200);

        // flush without and with stall
        cycle(0, 0, 1, 32'h3040, 0);
        cycle(0, 0, 0, 32'd0, 1);
        check("flush_instr", instr_d, 32'd0);
        check("flush_valid", {31'd0, valid_d}, 32'd0);
        free_cycle();
        frz_instr = instr_d; frz_pc_d = pc_d;
        cycle(0, 1, 0, 32'd0, 1);
        check("flush_stall_instr", instr_d, frz_instr);
        check("flush_stall_pc_d",  pc_d,    frz_pc_d);

        // misaligned and out-of-range fetches
        cycle(0, 0, 1, 32'h3002, 0);
        free_cycle();
        check("mis_adel", {31'd0, adel_d}, 32'd1);
        check("mis_pc", pc_f, 32'h3006);
        cycle(0, 0, 1, 32'h0000_1000, 0);
        free_cycle();
        check("low_adel", {31'd0, adel_d}, 32'd1);
        check("low_instr", instr_d, 32'd0);
        // last legal word, then first word past the window, then wrap
        cycle(0, 0, 1, 32'h6FFC, 0);
        free_cycle(); check("last_ok", {31'd0, adel_d}, 32'd0);
        free_cycle(); check("past_end", {31'd0, adel_d}, 32'd1);
        cycle(0, 0, 1, 32'hFFFF_FFFC, 0);
        free_cycle(); check("wrap", pc_f, 32'd0);

        // reset while a target is held
        cycle(0, 0, 1, 32'h3080, 0);
        cycle(0, 1, 1, 32'h3300, 0);
        cycle(1, 1, 1, 32'h3400, 1);
        check("rst_held", pc_f, 32'h3000);
        free_cycle();
        check("no_3300", pc_f, 32'h3004);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 7))
                0: tgt = IM_BASE + 32'($urandom_range(0, 4 * IM_WORDS - 1));
                1: tgt = $urandom;
                2: tgt = IM_BASE + 4 * IM_WORDS - 32'($urandom_range(0, 2) * 4);
                default: tgt = IM_BASE + 32'($urandom_range(0, IM_WORDS - 1) * 4);
            endcase
            cycle($urandom_range(0, 99) < 2,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) == 0,
                  tgt,
                  $urandom_range(0, 6) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
